// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch unit between the core PC and a
// variable-latency instruction memory port. A small tagged buffer returns
// already-fetched words in the same cycle; misses go through a one-request
// IDLE/REQ/WAIT handshake. Defining IFETCH_PREFETCH_EN adds a second buffer
// entry and a sequential next-word prefetch on hits.
module ifetch_unit #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_flush,
   output logic [XLEN-1:0] o_instr,
   output logic            o_instr_valid,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_gnt,
   input  logic            i_mem_rvalid,
   input  logic [XLEN-1:0] i_mem_rdata
);

   localparam int TAGW = XLEN - 2;
`ifdef IFETCH_PREFETCH_EN
   localparam int ENTRIES = 2;
`else
   localparam int ENTRIES = 1;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [ENTRIES-1:0]   r_valid;
   logic [TAGW-1:0]      r_tag  [ENTRIES];
   logic [XLEN-1:0]      r_data [ENTRIES];
   logic [TAGW-1:0]      r_reqTag;
   logic                 r_drop;
   logic                 r_memReq;

   logic [TAGW-1:0]      w_pcTag;
   logic                 w_hit;
   logic [XLEN-1:0]      w_hitData;
   logic                 w_loadReq;
   logic [TAGW-1:0]      w_loadTag;
   logic                 w_fill;
   logic [ENTRIES-1:0]   w_victimOh;

   assign w_pcTag = i_pc[XLEN-1:2];

   // Tag lookup: any valid entry holding the current PC's word is a hit.
   always_comb begin
      w_hit     = 1'b0;
      w_hitData = NOP_INSTR;
      for (int i = 0; i < ENTRIES; i++) begin
         if (r_valid[i] && (r_tag[i] == w_pcTag)) begin
            w_hit     = 1'b1;
            w_hitData = r_data[i];
         end
      end
   end

   assign o_instr_valid = w_hit && !i_flush;
   assign o_instr       = o_instr_valid ? w_hitData : NOP_INSTR;
   assign o_mem_req     = r_memReq;
   assign o_mem_addr    = {r_reqTag, 2'b00};

`ifdef IFETCH_PREFETCH_EN
   logic [TAGW-1:0] w_nextTag;
   logic            w_nextBuffered;
   logic            w_startPrefetch;

   assign w_nextTag = w_pcTag + TAGW'(1);

   // Prefetch pc+4 only when it is not already held and pc is not the top word.
   always_comb begin
      w_nextBuffered = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (r_valid[i] && (r_tag[i] == w_nextTag)) begin
            w_nextBuffered = 1'b1;
         end
      end
      w_startPrefetch = w_hit && !i_flush && !w_nextBuffered && !(&w_pcTag);
   end

   // Victim choice: an empty entry first, otherwise the one not serving pc.
   always_comb begin
      w_victimOh = 2'b01;
      if (!r_valid[0]) begin
         w_victimOh = 2'b01;
      end else if (!r_valid[1]) begin
         w_victimOh = 2'b10;
      end else if (r_tag[0] == w_pcTag) begin
         w_victimOh = 2'b10;
      end else begin
         w_victimOh = 2'b01;
      end
   end
`else
   // Victim choice: the single entry is always replaced.
   always_comb begin
      w_victimOh = 1'b1;
   end
`endif

   // Next-state logic: start a demand (or prefetch) request from IDLE, wait for
   // the grant in REQ, and accept the in-order response in WAIT.
   always_comb begin
      w_nextState = r_state;
      w_loadReq   = 1'b0;
      w_loadTag   = w_pcTag;
      w_fill      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!i_flush && !w_hit) begin
               w_loadReq   = 1'b1;
               w_loadTag   = w_pcTag;
               w_nextState = REQ;
            end
`ifdef IFETCH_PREFETCH_EN
            else if (w_startPrefetch) begin
               w_loadReq   = 1'b1;
               w_loadTag   = w_nextTag;
               w_nextState = REQ;
            end
`endif
         end
         REQ: begin
            if (i_mem_gnt) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (i_mem_rvalid) begin
               w_fill      = !r_drop && !i_flush;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State, request address and drop flag; a flush while a transaction is in
   // flight marks its response as stale rather than cancelling it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_reqTag <= '0;
         r_drop   <= 1'b0;
         r_memReq <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_memReq <= (w_nextState == REQ);
         if (w_loadReq) begin
            r_reqTag <= w_loadTag;
         end
         if ((r_state == WAIT) && i_mem_rvalid) begin
            r_drop <= 1'b0;
         end else if (i_flush && (r_state != IDLE)) begin
            r_drop <= 1'b1;
         end
      end
   end

   // Buffer update: flush clears every entry, otherwise a fresh response
   // is written into the victim entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (i_flush) begin
               r_valid[i] <= 1'b0;
            end else if (w_fill && w_victimOh[i]) begin
               r_valid[i] <= 1'b1;
               r_tag[i]   <= r_reqTag;
               r_data[i]  <= i_mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with a scoreboard monitor.
// Expected request addresses and presented instructions are queued by the
// stimulus; a monitor pops and compares them as the DUT presents them.
module tb_ifetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_pc;
   logic        i_flush;
   logic [31:0] o_instr;
   logic        o_instr_valid;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   int stallCfg = 0;
   logic holdResp = 1'b0;
   logic flushLevel = 1'b0;
   int flushReqCount = 0;
   int flushDoneCount = 0;
   int strayAtCycle = -1;

   logic [31:0] expReq[$];
   logic [31:0] expInstr[$];

   ifetch_unit #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk),
      .reset(reset),
      .i_pc(i_pc),
      .i_flush(i_flush),
      .o_instr(o_instr),
      .o_instr_valid(o_instr_valid),
      .o_mem_req(o_mem_req),
      .o_mem_addr(o_mem_addr),
      .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Instruction memory contents, hand-picked per address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0000_0000: memWord = 32'h0050_0113;
         32'h0000_0010: memWord = 32'h0010_0093;
         32'h0000_0040: memWord = 32'h0400_0093;
         32'h0000_0080: memWord = 32'h0800_0093;
         32'h0000_0100: memWord = 32'h1000_0113;
         32'h0000_0104: memWord = 32'h1040_0193;
         32'hFFFF_FFFC: memWord = 32'hFFC0_0213;
         default:       memWord = {16'hC0DE, a[15:0]};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] pc);
      i_pc = pc;
   endtask

   task automatic waitValid(output int lat);
      lat = 0;
      while (1) begin
         tick();
         lat++;
         if (o_instr_valid) break;
         if (lat >= 40) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_timeout: got no instr_valid, required one within 40 cycles");
            break;
         end
      end
   endtask

   // Memory responder: grant after stallCfg cycles, answer the next cycle.
   initial begin
      logic [31:0] pendAddr;
      logic        pending;
      int          waitCnt;
      pending = 1'b0;
      waitCnt = 0;
      pendAddr = '0;
      i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata = '0;
      i_flush = 1'b0;
      forever begin
         @(negedge clk);
         i_mem_gnt = 1'b0;
         i_mem_rvalid = 1'b0;
         i_flush = flushLevel;
         if (reset) begin
            pending = 1'b0;
            waitCnt = 0;
         end else begin
            if (cycleCount == strayAtCycle) begin
               i_flush = 1'b0;
               i_mem_rvalid = 1'b1;
               i_mem_rdata = 32'hDEAD_BEEF;
            end
            if (pending) begin
               pending = 1'b0;
               i_mem_rvalid = 1'b1;
               i_mem_rdata = memWord(pendAddr);
               if (flushReqCount > flushDoneCount) begin
                  i_flush = 1'b1;
                  flushDoneCount++;
               end
            end
            if (o_mem_req) begin
               if (waitCnt < stallCfg) begin
                  waitCnt++;
               end else begin
                  waitCnt = 0;
                  i_mem_gnt = 1'b1;
                  pending = !holdResp;
                  pendAddr = o_mem_addr;
               end
            end
         end
      end
   end

   // Scoreboard monitor: compare each new request and each newly presented instruction.
   initial begin
      logic        prevReq;
      logic        prevValid;
      logic [31:0] prevPc;
      logic [31:0] exp;
      prevReq = 1'b0;
      prevValid = 1'b0;
      prevPc = '0;
      forever begin
         @(negedge clk);
         #3;
         if (o_mem_req && !prevReq) begin
            if (expReq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_req: got request to %h, required none", o_mem_addr);
            end else begin
               exp = expReq.pop_front();
               checkOutput("req_addr", o_mem_addr, exp);
            end
         end
         if (o_instr_valid && (!prevValid || (i_pc != prevPc))) begin
            if (expInstr.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_instr: got %h at pc %h, required none", o_instr, i_pc);
            end else begin
               exp = expInstr.pop_front();
               checkOutput("instr", o_instr, exp);
            end
         end
         prevReq = o_mem_req;
         prevValid = o_instr_valid;
         prevPc = i_pc;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   // Directed stimulus sequence.
   initial begin
      int lat;
      int bound;
      reset = 1'b1;
      applyStimulus(32'h0);

      // Reset values
      tick();
      checkOutput("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
      checkOutput("rst_mem_addr", o_mem_addr, 32'd0);
      checkOutput("rst_valid", {31'd0, o_instr_valid}, 32'd0);
      checkOutput("rst_instr", o_instr, NOP);

      // Reset then miss at pc=0
      tick();
      expReq.push_back(32'h0);
`ifdef IFETCH_PREFETCH_EN
      expReq.push_back(32'h4);
`endif
      expInstr.push_back(32'h0050_0113);
      reset = 1'b0;
      tick();
      checkOutput("miss_req_c1", {31'd0, o_mem_req}, 32'd1);
      checkOutput("miss_addr_c1", o_mem_addr, 32'h0);
      waitValid(lat);
      checkOutput("miss_latency", 32'(1 + lat), 32'd3);

      // Hit hold
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("hold_valid", {31'd0, o_instr_valid}, 32'd1);
`ifndef IFETCH_PREFETCH_EN
         checkOutput("hold_no_req", {31'd0, o_mem_req}, 32'd0);
`endif
      end

      // Grant stall of 4 cycles at pc=0x40
      stallCfg = 4;
      expReq.push_back(32'h40);
`ifdef IFETCH_PREFETCH_EN
      expReq.push_back(32'h44);
`endif
      expInstr.push_back(32'h0400_0093);
      applyStimulus(32'h40);
      lat = 0;
      while (1) begin
         tick();
         lat++;
         if (o_mem_req) checkOutput("stall_addr", o_mem_addr, 32'h40);
         if (o_instr_valid) break;
         if (lat >= 40) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_timeout: got no instr_valid, required one within 40 cycles");
            break;
         end
      end
      stallCfg = 0;
      checkOutput("stall_latency", 32'(lat), 32'd7);
      repeat (6) tick();

      // Flush coincident with the response for pc=0x10
      expReq.push_back(32'h10);
      expReq.push_back(32'h10);
`ifdef IFETCH_PREFETCH_EN
      expReq.push_back(32'h14);
`endif
      expInstr.push_back(32'h0010_0093);
      flushReqCount++;
      applyStimulus(32'h10);
      bound = 0;
      while (flushDoneCount != flushReqCount && bound < 20) begin
         tick();
         bound++;
      end
      checkOutput("flush_seen", 32'(flushDoneCount), 32'(flushReqCount));
      checkOutput("flush_cycle_valid", {31'd0, o_instr_valid}, 32'd0);
      tick();
      checkOutput("after_flush_valid", {31'd0, o_instr_valid}, 32'd0);
      waitValid(lat);
      checkOutput("refetch_latency", 32'(lat), 32'd3);
      repeat (6) tick();

`ifdef IFETCH_PREFETCH_EN
      // Sequential prefetch
      expReq.push_back(32'h100);
      expReq.push_back(32'h104);
      expInstr.push_back(32'h1000_0113);
      expInstr.push_back(32'h1040_0193);
      applyStimulus(32'h100);
      waitValid(lat);
      checkOutput("pf_demand_latency", 32'(lat), 32'd3);
      repeat (4) tick();
      expReq.push_back(32'h108);
      applyStimulus(32'h104);
      #1;
      checkOutput("pf_hit_valid", {31'd0, o_instr_valid}, 32'd1);
      checkOutput("pf_hit_instr", o_instr, 32'h1040_0193);
      repeat (6) tick();
      expReq.push_back(32'hFFFF_FFFC);
      expInstr.push_back(32'hFFC0_0213);
      applyStimulus(32'hFFFF_FFFC);
      waitValid(lat);
      checkOutput("top_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("top_no_prefetch", {31'd0, o_mem_req}, 32'd0);
      end
`endif

      // Reset while in WAIT, then a stray response in IDLE
      holdResp = 1'b1;
      expReq.push_back(32'h80);
      applyStimulus(32'h80);
      repeat (3) tick();
      reset = 1'b1;
      #1;
      checkOutput("midrst_mem_req", {31'd0, o_mem_req}, 32'd0);
      checkOutput("midrst_mem_addr", o_mem_addr, 32'd0);
      checkOutput("midrst_valid", {31'd0, o_instr_valid}, 32'd0);
      checkOutput("midrst_instr", o_instr, NOP);
      flushLevel = 1'b1;
      holdResp = 1'b0;
      applyStimulus(32'h0);
      tick();
      expReq.push_back(32'h0);
`ifdef IFETCH_PREFETCH_EN
      expReq.push_back(32'h4);
`endif
      expInstr.push_back(32'h0050_0113);
      reset = 1'b0;
      strayAtCycle = cycleCount + 1;
      tick();
      flushLevel = 1'b0;
      tick();
      checkOutput("stray_ignored_valid", {31'd0, o_instr_valid}, 32'd0);
      checkOutput("post_stray_req", {31'd0, o_mem_req}, 32'd1);
      waitValid(lat);
      checkOutput("post_stray_latency", 32'(lat), 32'd2);
      repeat (6) tick();

      checkOutput("req_queue_empty", 32'(expReq.size()), 32'd0);
      checkOutput("instr_queue_empty", 32'(expInstr.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
